mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_if.sv | 47 ++++
 rtl/mem_bus_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the two cache refill ports, the shared memory bus and the arbiter.
// The master modport is the arbiter's view. The slave modport is the view of the caches and memory.
interface mem_bus_arbiter_if;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_gnt;
  logic        ic_rvalid;

  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic        dc_gnt;
  logic        dc_rvalid;
  logic        dc_wnext;
  logic        dc_wdone;

  logic [31:0] rdata;
  logic        rlast;

  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_req_we;
  logic        bus_rvalid;
  logic        bus_rlast;
  logic [31:0] bus_rdata;
  logic        bus_wvalid;
  logic        bus_wready;
  logic [31:0] bus_wdata;
  logic        bus_wlast;
  logic        bus_bvalid;

  modport master (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata,
    input  bus_req_ready, bus_rvalid, bus_rlast, bus_rdata, bus_wready, bus_bvalid,
    output ic_gnt, ic_rvalid, dc_gnt, dc_rvalid, dc_wnext, dc_wdone, rdata, rlast,
    output bus_req_valid, bus_req_addr, bus_req_we, bus_wvalid, bus_wdata, bus_wlast
  );

  modport slave (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata,
    output bus_req_ready, bus_rvalid, bus_rlast, bus_rdata, bus_wready, bus_bvalid,
    input  ic_gnt, ic_rvalid, dc_gnt, dc_rvalid, dc_wnext, dc_wdone, rdata, rlast,
    input  bus_req_valid, bus_req_addr, bus_req_we, bus_wvalid, bus_wdata, bus_wlast
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that puts icache refills and dcache refills/writebacks onto one burst memory bus.
// Only one line transaction is outstanding at a time. Every transaction is followed by an idle cycle.
module mem_bus_arbiter #(
  parameter int unsigned LINE_WORDS = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_bus_arbiter_if.master arb
);

  localparam int unsigned BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, ADDR, RDATA, WDATA, WRESP} state_e;
  typedef enum logic {OWN_IC = 1'b0, OWN_DC = 1'b1} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  // NOTE: state registers use non-blocking assignments only. A blocking assignment here
  // would make the order of the process matter and would mismatch between simulation and synthesis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_IC;
      last_q  <= OWN_IC;
      addr_q  <= '0;
      we_q    <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      beat_q  <= beat_d;
    end
  end

  // NOTE: every signal this block writes gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    last_d            = last_q;
    addr_d            = addr_q;
    we_d              = we_q;
    beat_d            = beat_q;

    arb.ic_gnt        = 1'b0;
    arb.ic_rvalid     = 1'b0;
    arb.dc_gnt        = 1'b0;
    arb.dc_rvalid     = 1'b0;
    arb.dc_wnext      = 1'b0;
    arb.dc_wdone      = 1'b0;
    arb.rdata         = '0;
    arb.rlast         = 1'b0;
    arb.bus_req_valid = 1'b0;
    arb.bus_req_addr  = '0;
    arb.bus_req_we    = 1'b0;
    arb.bus_wvalid    = 1'b0;
    arb.bus_wdata     = '0;
    arb.bus_wlast     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb.ic_req || arb.dc_req) begin
          // On a tie, the requester that was not served last wins.
          if (arb.ic_req && arb.dc_req) owner_d = (last_q == OWN_DC) ? OWN_IC : OWN_DC;
          else                          owner_d = arb.dc_req ? OWN_DC : OWN_IC;
          addr_d  = (owner_d == OWN_DC) ? arb.dc_addr : arb.ic_addr;
          we_d    = (owner_d == OWN_DC) && arb.dc_we;
          state_d = ADDR;
        end
      end

      ADDR: begin
        arb.bus_req_valid = 1'b1;
        arb.bus_req_addr  = addr_q;
        arb.bus_req_we    = we_q;
        if (arb.bus_req_ready) begin
          arb.ic_gnt = (owner_q == OWN_IC);
          arb.dc_gnt = (owner_q == OWN_DC);
          state_d    = we_q ? WDATA : RDATA;
        end
      end

      RDATA: begin
        arb.rdata     = arb.bus_rdata;
        arb.rlast     = arb.bus_rlast;
        arb.ic_rvalid = (owner_q == OWN_IC) && arb.bus_rvalid;
        arb.dc_rvalid = (owner_q == OWN_DC) && arb.bus_rvalid;
        if (arb.bus_rvalid && arb.bus_rlast) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end

      WDATA: begin
        arb.bus_wvalid = 1'b1;
        arb.bus_wdata  = arb.dc_wdata;
        arb.bus_wlast  = (beat_q == LAST_BEAT);
        arb.dc_wnext   = arb.bus_wready;
        if (arb.bus_wready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = WRESP;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
          end
        end
      end

      WRESP: begin
        if (arb.bus_bvalid) begin
          arb.dc_wdone = 1'b1;
          last_d       = OWN_DC;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
